change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL have parameter PULSE_CYCLES, default 4, giving the number of cycles each coin-eject pulse is held high (legal range 1..15).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 4, giving the number of low cycles between consecutive coin pulses (legal range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port dispense_req, input, 1 bit: one-cycle pulse from the controller's product_dispensed.
REQ-006 The block SHALL have port change_in, input, 4 bits: change owed, unsigned units, sampled with dispense_req.
REQ-007 The block SHALL have ports hopper5_empty and hopper1_empty, input, 1 bit each: high when that hopper has no coins.
REQ-008 The block SHALL have port fault_ack, input, 1 bit: operator retry pulse.
REQ-009 The block SHALL have ports coin5_pulse and coin1_pulse, output, 1 bit each: eject drive for a 5-unit and a 1-unit coin.
REQ-010 The block SHALL have ports busy, done, fault (output, 1 bit each) and remaining (output, 4 bits): change still owed.

Function
REQ-011 The FSM SHALL have states IDLE, SELECT, PULSE, GAP, DONE and FAULT.
REQ-012 In IDLE, dispense_req with change_in!=0 SHALL latch remaining=change_in, assert busy from the next cycle and move to SELECT.
REQ-013 In IDLE, dispense_req with change_in==0 SHALL move to DONE, so done is high the next cycle and no coin pulses occur.
REQ-014 dispense_req SHALL be ignored in every state other than IDLE.
REQ-015 SELECT SHALL be a single cycle that samples the hopper flags only in that cycle.
REQ-016 SELECT SHALL apply the first matching rule: remaining==0 -> DONE; remaining>=5 and !hopper5_empty -> PULSE (denom 5); !hopper1_empty -> PULSE (denom 1); otherwise -> FAULT.
REQ-017 In PULSE, the selected coin output SHALL be high for exactly PULSE_CYCLES cycles, with the other coin output low.
REQ-018 remaining SHALL decrease by the denomination on the last PULSE cycle, then the FSM SHALL move to GAP.
REQ-019 GAP SHALL hold both coin outputs low for GAP_CYCLES cycles, then move to SELECT.
REQ-020 DONE SHALL assert done for exactly one cycle with busy low and remaining 0, then return to IDLE.
REQ-021 FAULT SHALL hold fault=1 and busy=1, freeze remaining, and keep both coin outputs low.
REQ-022 In FAULT, fault_ack SHALL move the FSM to SELECT, and hopper state SHALL be re-evaluated there.
REQ-023 coin5_pulse and coin1_pulse SHALL never be high in the same cycle.
REQ-024 busy SHALL be high in SELECT, PULSE, GAP and FAULT only.
REQ-025 remaining arithmetic SHALL be 4-bit unsigned and SHALL never underflow, because selection guarantees denom<=remaining.

Reset
REQ-026 On reset, including mid-pulse, the FSM SHALL enter IDLE.
REQ-027 The cycle after reset is sampled, all outputs SHALL be 0: coin pulses, busy, done, fault, remaining and the cycle timer.
REQ-028 Reset SHALL take priority over every other input.

Configuration
REQ-029 When macro CHANGE_DISPENSER_LEDGER_EN is defined, the block SHALL add output paid_total (8 bits), incremented by the denomination on the last cycle of each PULSE.
REQ-030 paid_total SHALL saturate at 255 and SHALL be cleared only by reset.
REQ-031 Without CHANGE_DISPENSER_LEDGER_EN, the paid_total port and its register SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-032 Shared package vend_pkg SHALL hold the state enum typedef, the coin denominations COIN_HI=5 and COIN_LO=1, and the 4-bit amount typedef.
REQ-033 The PULSE and GAP durations SHALL be timed by one sub-module, pulse_timer: a 4-bit down-counter with load value, start and expire outputs, reused for both states.

Verification
REQ-034 The bench SHALL cover: change_in=7, hoppers full, req at cycle N -> coin5 high N+2..N+5, coin1 high N+11..N+14 and N+20..N+23, done high at N+29, remaining 7->2->1->0.
REQ-035 The bench SHALL cover: change_in=0 -> done high at N+1 only, busy never high, no coin pulses.
REQ-036 The bench SHALL cover: change_in=6 with hopper5_empty=1 -> six coin1 pulses, no coin5 pulse, then done.
REQ-037 The bench SHALL cover: change_in=3 with hopper1_empty=1 -> fault high at N+2 with remaining=3; clearing the flag and pulsing fault_ack -> three coin1 pulses, then done.
REQ-038 The bench SHALL cover: reset asserted during coin5 pulse -> next cycle all outputs 0 and FSM in IDLE; a subsequent req works normally.
REQ-039 The bench SHALL cover: dispense_req repeated while busy -> ignored, remaining unaffected; and with CHANGE_DISPENSER_LEDGER_EN defined, paid_total ends at 7 after the first scenario.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the change dispenser.
package vend_pkg;

    typedef logic [3:0] amount_t;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StPulse,
        StGap,
        StDone,
        StFault
    } state_e;

    localparam amount_t COIN_HI = 4'd5;
    localparam amount_t COIN_LO = 4'd1;

endpackage

// File: rtl/pulse_timer.sv
// 4-bit down-counter shared by the coin pulse and inter-coin gap phases.
// Expires while the count sits at zero; start reloads it.
module pulse_timer (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [3:0] i_load,
    output logic       o_expire
);

    logic [3:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= 4'd0;
        end else if (i_start) begin
            r_count <= i_load;
        end else if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_expire = (r_count == 4'd0);

endmodule

// File: rtl/change_dispenser.sv
// Pays out owed change as 5- and 1-unit coin eject pulses, greedy on the 5s.
// Optional ledger output paid_total enabled by CHANGE_DISPENSER_LEDGER_EN.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dispense_req,
    input  logic [3:0] change_in,
    input  logic       hopper5_empty,
    input  logic       hopper1_empty,
    input  logic       fault_ack,
    output logic       coin5_pulse,
    output logic       coin1_pulse,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [3:0] remaining
`ifdef CHANGE_DISPENSER_LEDGER_EN
    ,
    output logic [7:0] paid_total
`endif
);

    state_e  r_state;
    state_e  w_state_next;
    amount_t r_remaining;
    logic    r_denom_hi;
    logic    w_sel_hi;
    logic    w_pay;
    logic    w_timer_start;
    logic    [3:0] w_timer_load;
    logic    w_timer_expire;
    amount_t w_denom;

    assign w_denom = r_denom_hi ? COIN_HI : COIN_LO;

    pulse_timer u_timer (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_start  (w_timer_start),
        .i_load   (w_timer_load),
        .o_expire (w_timer_expire)
    );

    always_comb begin
        w_state_next  = r_state;
        w_sel_hi      = 1'b0;
        w_pay         = 1'b0;
        w_timer_start = 1'b0;
        w_timer_load  = 4'd0;
        unique case (r_state)
            StIdle: begin
                if (dispense_req) begin
                    w_state_next = (change_in != 4'd0) ? StSelect : StDone;
                end
            end
            StSelect: begin
                if (r_remaining == 4'd0) begin
                    w_state_next = StDone;
                end else if (r_remaining >= COIN_HI && !hopper5_empty) begin
                    w_state_next  = StPulse;
                    w_sel_hi      = 1'b1;
                    w_timer_start = 1'b1;
                    w_timer_load  = 4'(PULSE_CYCLES - 1);
                end else if (!hopper1_empty) begin
                    w_state_next  = StPulse;
                    w_timer_start = 1'b1;
                    w_timer_load  = 4'(PULSE_CYCLES - 1);
                end else begin
                    w_state_next = StFault;
                end
            end
            StPulse: begin
                if (w_timer_expire) begin
                    w_state_next  = StGap;
                    w_pay         = 1'b1;
                    w_timer_start = 1'b1;
                    w_timer_load  = 4'(GAP_CYCLES - 1);
                end
            end
            StGap: begin
                if (w_timer_expire) begin
                    w_state_next = StSelect;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            StFault: begin
                if (fault_ack) begin
                    w_state_next = StSelect;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_remaining <= 4'd0;
            r_denom_hi  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StIdle && dispense_req && change_in != 4'd0) begin
                r_remaining <= change_in;
            end else if (w_pay) begin
                // Selection only picks a coin no larger than what is owed.
                r_remaining <= r_remaining - w_denom;
            end
            if (r_state == StSelect) begin
                r_denom_hi <= w_sel_hi;
            end
        end
    end

`ifdef CHANGE_DISPENSER_LEDGER_EN
    logic [7:0] r_paid_total;
    logic [8:0] w_paid_sum;

    assign w_paid_sum = {1'b0, r_paid_total} + {5'd0, w_denom};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_paid_total <= 8'd0;
        end else if (w_pay) begin
            r_paid_total <= w_paid_sum[8] ? 8'hff : w_paid_sum[7:0];
        end
    end

    assign paid_total = r_paid_total;
`endif

    assign coin5_pulse = (r_state == StPulse) && r_denom_hi;
    assign coin1_pulse = (r_state == StPulse) && !r_denom_hi;
    assign busy        = (r_state == StSelect) || (r_state == StPulse) ||
                         (r_state == StGap) || (r_state == StFault);
    assign done        = (r_state == StDone);
    assign fault       = (r_state == StFault);
    assign remaining   = r_remaining;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized and directed bench for change_dispenser against a per-cycle trace model.
module tb_change_dispenser;

    localparam int unsigned P = 4;
    localparam int unsigned G = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dispense_req = 1'b0;
    logic [3:0] change_in = 4'd0;
    logic       hopper5_empty = 1'b0;
    logic       hopper1_empty = 1'b0;
    logic       fault_ack = 1'b0;
    logic       coin5_pulse, coin1_pulse, busy, done, fault;
    logic [3:0] remaining;
`ifdef CHANGE_DISPENSER_LEDGER_EN
    logic [7:0] paid_total;
`endif

    always #5 clk = ~clk;

    change_dispenser #(
        .PULSE_CYCLES (P),
        .GAP_CYCLES   (G)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .dispense_req  (dispense_req),
        .change_in     (change_in),
        .hopper5_empty (hopper5_empty),
        .hopper1_empty (hopper1_empty),
        .fault_ack     (fault_ack),
        .coin5_pulse   (coin5_pulse),
        .coin1_pulse   (coin1_pulse),
        .busy          (busy),
        .done          (done),
        .fault         (fault),
        .remaining     (remaining)
`ifdef CHANGE_DISPENSER_LEDGER_EN
        ,
        .paid_total    (paid_total)
`endif
    );

    int total = 0;
    int bad = 0;
    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    logic [8:0] w_obs;

    // {coin5, coin1, busy, done, fault, remaining}
    assign w_obs = {coin5_pulse, coin1_pulse, busy, done, fault, remaining};

    function automatic logic [8:0] pk(bit c5, bit c1, bit b, bit d, bit f, int rem);
        return {c5, c1, b, d, f, 4'(rem)};
    endfunction

    // Expected outputs after each clock edge, starting with the edge that takes the request
    // (or fault_ack). Returns 1 if the payout stalls in a fault.
    function automatic bit build_trace(int rem_in, bit h5e, bit h1e, bit from_req);
        int rem = rem_in;
        int d;
        exp_q.delete();
        if (from_req && rem == 0) begin
            exp_q.push_back(pk(0, 0, 0, 1, 0, 0));
            exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
            return 1'b0;
        end
        while (1) begin
            exp_q.push_back(pk(0, 0, 1, 0, 0, rem));
            if (rem == 0) begin
                exp_q.push_back(pk(0, 0, 0, 1, 0, 0));
                exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
                return 1'b0;
            end
            if (rem >= 5 && !h5e) d = 5;
            else if (!h1e) d = 1;
            else begin
                repeat (3) exp_q.push_back(pk(0, 0, 1, 0, 1, rem));
                return 1'b1;
            end
            repeat (P) exp_q.push_back(pk(d == 5, d == 1, 1, 0, 0, rem));
            rem = rem - d;
            repeat (G) exp_q.push_back(pk(0, 0, 1, 0, 0, rem));
        end
    endfunction

    task automatic kick(input logic [3:0] c);
        dispense_req = 1'b1;
        change_in    = c;
    endtask

    // Clock n edges recording outputs; optionally throw spurious requests while not idle.
    task automatic run_trace(input int n, input bit noise);
        obs_q.delete();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            obs_q.push_back(w_obs);
            fault_ack = 1'b0;
            if (noise && i < n - 1) begin
                dispense_req = 1'($urandom_range(0, 1));
                change_in    = 4'($urandom_range(0, 15));
            end else begin
                dispense_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        reset        = 1'b1;
        dispense_req = 1'b1;
        change_in    = 4'd5;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (w_obs !== 9'd0) begin
                bad++;
                $display("FAIL reset_outputs: got %b want 000000000", w_obs);
            end
            total++;
            if (dut.u_timer.r_count !== 4'd0) begin
                bad++;
                $display("FAIL reset_timer: got %0d want 0", dut.u_timer.r_count);
            end
        end
`ifdef CHANGE_DISPENSER_LEDGER_EN
        total++;
        if (paid_total !== 8'd0) begin
            bad++;
            $display("FAIL reset_ledger: got %0d want 0", paid_total);
        end
`endif
        reset        = 1'b0;
        dispense_req = 1'b0;
    endtask

    task automatic test_change7;
        void'(build_trace(7, 0, 0, 1));
        kick(4'd7);
        run_trace(exp_q.size(), 0);
        foreach (exp_q[k]) begin
            total++;
            if (obs_q[k] !== exp_q[k]) begin
                bad++;
                $display("FAIL change7 N+%0d: got %b want %b", k + 1, obs_q[k], exp_q[k]);
            end
        end
        total++;
        if (obs_q[1] !== 9'b10100_0111 || obs_q[28] !== 9'b00010_0000) begin
            bad++;
            $display("FAIL change7_anchor: got N+2=%b N+29=%b want 101000111 000100000",
                     obs_q[1], obs_q[28]);
        end
`ifdef CHANGE_DISPENSER_LEDGER_EN
        total++;
        if (paid_total !== 8'd7) begin
            bad++;
            $display("FAIL ledger7: got %0d want 7", paid_total);
        end
`endif
    endtask

    task automatic test_zero;
        void'(build_trace(0, 0, 0, 1));
        kick(4'd0);
        run_trace(exp_q.size() + 2, 0);
        for (int k = 0; k < obs_q.size(); k++) begin
            total++;
            if (obs_q[k] !== ((k < exp_q.size()) ? exp_q[k] : 9'd0)) begin
                bad++;
                $display("FAIL zero N+%0d: got %b", k + 1, obs_q[k]);
            end
        end
    endtask

    task automatic test_no_hopper5;
        hopper5_empty = 1'b1;
        void'(build_trace(6, 1, 0, 1));
        kick(4'd6);
        run_trace(exp_q.size(), 0);
        foreach (exp_q[k]) begin
            total++;
            if (obs_q[k] !== exp_q[k]) begin
                bad++;
                $display("FAIL no_hopper5 N+%0d: got %b want %b", k + 1, obs_q[k], exp_q[k]);
            end
        end
        hopper5_empty = 1'b0;
    endtask

    task automatic test_fault_retry;
        hopper1_empty = 1'b1;
        void'(build_trace(3, 0, 1, 1));
        kick(4'd3);
        run_trace(exp_q.size(), 0);
        foreach (exp_q[k]) begin
            total++;
            if (obs_q[k] !== exp_q[k]) begin
                bad++;
                $display("FAIL fault_hold N+%0d: got %b want %b", k + 1, obs_q[k], exp_q[k]);
            end
        end
        hopper1_empty = 1'b0;
        fault_ack     = 1'b1;
        void'(build_trace(3, 0, 0, 0));
        run_trace(exp_q.size(), 0);
        foreach (exp_q[k]) begin
            total++;
            if (obs_q[k] !== exp_q[k]) begin
                bad++;
                $display("FAIL fault_retry A+%0d: got %b want %b", k + 1, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_reset_mid_pulse;
        kick(4'd7);
        run_trace(3, 0);
        total++;
        if (obs_q[2] !== 9'b10100_0111) begin
            bad++;
            $display("FAIL mid_pulse_pre: got %b want 101000111", obs_q[2]);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (w_obs !== 9'd0 || dut.u_timer.r_count !== 4'd0) begin
            bad++;
            $display("FAIL mid_pulse_reset: got %b timer %0d want 000000000 timer 0",
                     w_obs, dut.u_timer.r_count);
        end
        total++;
        if (dut.r_state !== vend_pkg::StIdle) begin
            bad++;
            $display("FAIL mid_pulse_state: got %0d want idle", dut.r_state);
        end
        reset = 1'b0;
        void'(build_trace(7, 0, 0, 1));
        kick(4'd7);
        run_trace(exp_q.size(), 0);
        foreach (exp_q[k]) begin
            total++;
            if (obs_q[k] !== exp_q[k]) begin
                bad++;
                $display("FAIL after_reset N+%0d: got %b want %b", k + 1, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_req_while_busy;
        void'(build_trace(9, 0, 0, 1));
        kick(4'd9);
        run_trace(exp_q.size(), 1);
        foreach (exp_q[k]) begin
            total++;
            if (obs_q[k] !== exp_q[k]) begin
                bad++;
                $display("FAIL busy_req N+%0d: got %b want %b", k + 1, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_random;
        int c;
        int rem;
        bit stalled;
        for (int it = 0; it < 16; it++) begin
            c             = int'($urandom_range(0, 15));
            hopper5_empty = 1'($urandom_range(0, 1));
            hopper1_empty = ($urandom_range(0, 3) == 0);
            stalled = build_trace(c, hopper5_empty, hopper1_empty, 1);
            kick(4'(c));
            run_trace(exp_q.size(), 1);
            foreach (exp_q[k]) begin
                total++;
                if (obs_q[k] !== exp_q[k]) begin
                    bad++;
                    $display("FAIL random it%0d chg%0d N+%0d: got %b want %b",
                             it, c, k + 1, obs_q[k], exp_q[k]);
                end
            end
            if (stalled) begin
                rem           = int'(exp_q[exp_q.size() - 1][3:0]);
                hopper5_empty = 1'b0;
                hopper1_empty = 1'b0;
                fault_ack     = 1'b1;
                void'(build_trace(rem, 0, 0, 0));
                run_trace(exp_q.size(), 1);
                foreach (exp_q[k]) begin
                    total++;
                    if (obs_q[k] !== exp_q[k]) begin
                        bad++;
                        $display("FAIL random_retry it%0d A+%0d: got %b want %b",
                                 it, k + 1, obs_q[k], exp_q[k]);
                    end
                end
            end
        end
        hopper5_empty = 1'b0;
        hopper1_empty = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_change7();
        test_zero();
        test_no_hopper5();
        test_fault_retry();
        test_reset_mid_pulse();
        test_req_while_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
